// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter over N requesters with optional max-hold under contention; one-cycle request-to-grant.
// Outputs are registered; no backpressure, an owner keeps the grant while it requests (bounded by MAX_HOLD if contended).
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDW     = (N > 2) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           gnt_new
);

    localparam logic [7:0]     HSAT    = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] PTR_RST = IDW'(N - 1);

    logic [N-1:0]   own_vec, own_vec_nxt;
    logic [IDW-1:0] own_id, own_id_nxt;
    logic           busy, busy_nxt;
    logic           new_pls, new_pls_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic [7:0]     hcnt, hcnt_nxt;

    logic           owner_req;
    logic           contended;
    logic           force_rel;
    logic [N-1:0]   arb_req;
    logic           found;
    logic [IDW-1:0] win;
    int             best_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_vec <= '0;
            own_id  <= '0;
            busy    <= 1'b0;
            new_pls <= 1'b0;
            ptr     <= PTR_RST;
            hcnt    <= '0;
        end else begin
            own_vec <= own_vec_nxt;
            own_id  <= own_id_nxt;
            busy    <= busy_nxt;
            new_pls <= new_pls_nxt;
            ptr     <= ptr_nxt;
            hcnt    <= hcnt_nxt;
        end
    end

    always_comb begin
        owner_req = busy && req[own_id];
        contended = |(req & ~own_vec);
        force_rel = (MAX_HOLD != 0) && owner_req && (hcnt == HSAT) && contended;
        arb_req   = force_rel ? (req & ~own_vec) : req;

        // Winner is the requester with the smallest rotational distance past ptr.
        found  = 1'b0;
        win    = '0;
        best_d = N;
        for (int j = 0; j < N; j++) begin
            if (arb_req[j] && (((j - int'(ptr) - 1 + 2 * N) % N) < best_d)) begin
                best_d = (j - int'(ptr) - 1 + 2 * N) % N;
                win    = IDW'(j);
                found  = 1'b1;
            end
        end

        own_vec_nxt = own_vec;
        own_id_nxt  = own_id;
        busy_nxt    = busy;
        new_pls_nxt = 1'b0;
        ptr_nxt     = ptr;
        hcnt_nxt    = hcnt;

        if (owner_req && !force_rel) begin
            hcnt_nxt = (hcnt == HSAT) ? hcnt : hcnt + 8'd1;
        end else if (found) begin
            own_vec_nxt = '0;
            own_vec_nxt[win] = 1'b1;
            own_id_nxt  = win;
            busy_nxt    = 1'b1;
            new_pls_nxt = 1'b1;
            ptr_nxt     = win;
            hcnt_nxt    = '0;
        end else begin
            own_vec_nxt = '0;
            own_id_nxt  = '0;
            busy_nxt    = 1'b0;
            hcnt_nxt    = '0;
        end
    end

    always_comb begin
        gnt       = own_vec;
        gnt_id    = own_id;
        gnt_valid = busy;
        gnt_new   = new_pls;
    end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: directed vector table, corner sequences, and random traffic against a reference model.
module tb_rr_arbiter_n;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] ga, gb;
    logic [1:0] ida, idb;
    logic       va, vb, na, nb;

    always #5 clk = ~clk;

    rr_arbiter_n #(.N(4), .MAX_HOLD(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(ga), .gnt_id(ida), .gnt_valid(va), .gnt_new(na)
    );

    rr_arbiter_n #(.N(4), .MAX_HOLD(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gb), .gnt_id(idb), .gnt_valid(vb), .gnt_new(nb)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
        logic       nw;
    } vec_t;

    vec_t tbl[26];

    // reference model state, index 0 = MAX_HOLD 4, index 1 = MAX_HOLD 0
    int   m_own[2];
    int   m_ptr[2];
    int   m_hc[2];
    int   mh[2];
    logic m_nw[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = -1;
            m_ptr[k] = N - 1;
            m_hc[k]  = 0;
            m_nw[k]  = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic [3:0] r);
        int         lim;
        int         w;
        logic       arb;
        logic [3:0] m;
        lim = (mh[k] == 0) ? 255 : mh[k] - 1;
        arb = 1'b1;
        m   = r;
        if (m_own[k] >= 0 && r[m_own[k]]) begin
            if (mh[k] != 0 && m_hc[k] == lim && (r & ~(4'b0001 << m_own[k])) != 4'b0000) begin
                m[m_own[k]] = 1'b0;
            end else begin
                arb = 1'b0;
                if (m_hc[k] < lim) m_hc[k]++;
                m_nw[k] = 1'b0;
            end
        end
        if (arb) begin
            w = -1;
            for (int s = 1; s <= N; s++)
                if (w < 0 && m[(m_ptr[k] + s) % N]) w = (m_ptr[k] + s) % N;
            if (w >= 0) begin
                m_own[k] = w;
                m_ptr[k] = w;
                m_hc[k]  = 0;
                m_nw[k]  = 1'b1;
            end else begin
                m_own[k] = -1;
                m_hc[k]  = 0;
                m_nw[k]  = 1'b0;
            end
        end
    endtask

    function automatic logic [3:0] exp_gnt(input int o);
        return (o < 0) ? 4'b0000 : 4'(4'b0001 << o);
    endfunction

    function automatic logic [1:0] exp_id(input int o);
        return (o < 0) ? 2'd0 : 2'(o);
    endfunction

    initial begin
        int newcnt;
        int last_seen[4];
        int maxgap[4];

        tbl[0]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[1]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1};
        tbl[4]  = '{4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[5]  = '{4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[6]  = '{4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[7]  = '{4'b1111, 4'b0100, 2'd2, 1'b1, 1'b1};
        tbl[8]  = '{4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[9]  = '{4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[10] = '{4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[11] = '{4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1};
        tbl[12] = '{4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[13] = '{4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[14] = '{4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[15] = '{4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[16] = '{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
        tbl[17] = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[18] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[19] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        tbl[20] = '{4'b0110, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[21] = '{4'b0110, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[22] = '{4'b0110, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[23] = '{4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1};
        tbl[24] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[25] = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};

        mh[0] = 4;
        mh[1] = 0;

        // reset state
        do_reset();
        chk("reset_outputs", {24'd0, ga, ida, va, na}, 32'd0);
        chk("reset_hcnt", {24'd0, dut_a.hcnt}, 32'd0);
        chk("reset_ptr", {30'd0, dut_a.ptr}, 32'd3);

        // directed vector table on the MAX_HOLD=4 instance
        for (int i = 0; i < 26; i++) begin
            req = tbl[i].req;
            tick();
            chk($sformatf("tbl%0d_gnt", i), {28'd0, ga}, {28'd0, tbl[i].gnt});
            chk($sformatf("tbl%0d_id", i), {30'd0, ida}, {30'd0, tbl[i].id});
            chk($sformatf("tbl%0d_vld", i), {31'd0, va}, {31'd0, tbl[i].vld});
            chk($sformatf("tbl%0d_new", i), {31'd0, na}, {31'd0, tbl[i].nw});
        end

        // lone requester holds indefinitely, hcnt saturates
        do_reset();
        req = 4'b0100;
        newcnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("solo_gnt", {28'd0, ga}, 32'h4);
            newcnt += int'(na);
        end
        chk("solo_new_count", newcnt, 1);
        chk("solo_hcnt_sat", {24'd0, dut_a.hcnt}, 32'd3);

        // asynchronous reset mid-grant
        do_reset();
        req = 4'b0010;
        tick();
        chk("pre_rst_gnt", {28'd0, ga}, 32'h2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {24'd0, ga, ida, va, na}, 32'd0);
        req = 4'b1111;
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_gnt", {28'd0, ga}, 32'h1);
        chk("post_rst_new", {31'd0, na}, 32'd1);

        // unlimited hold instance
        do_reset();
        req = 4'b1111;
        newcnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("unl_gnt", {28'd0, gb}, 32'h1);
            newcnt += int'(nb);
        end
        chk("unl_new_count", newcnt, 1);
        req = 4'b1110;
        tick();
        chk("unl_handover_gnt", {28'd0, gb}, 32'h2);
        chk("unl_handover_new", {31'd0, nb}, 32'd1);

        // fairness with all requesting
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            last_seen[i] = 0;
            maxgap[i]    = 0;
        end
        for (int c = 1; c <= 48; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (ga[i]) begin
                    if (c - last_seen[i] > maxgap[i]) maxgap[i] = c - last_seen[i];
                    last_seen[i] = c;
                end
            end
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("fair_gap%0d", i), {31'd0, maxgap[i] <= (N - 1) * 4 + 1}, 32'd1);

        // random traffic against reference model, both instances
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            tick();
            model_step(0, req);
            model_step(1, req);
            chk("rnd_a_gnt", {28'd0, ga}, {28'd0, exp_gnt(m_own[0])});
            chk("rnd_a_id", {30'd0, ida}, {30'd0, exp_id(m_own[0])});
            chk("rnd_a_vld", {31'd0, va}, {31'd0, m_own[0] >= 0});
            chk("rnd_a_new", {31'd0, na}, {31'd0, m_nw[0]});
            chk("rnd_b_gnt", {28'd0, gb}, {28'd0, exp_gnt(m_own[1])});
            chk("rnd_b_id", {30'd0, idb}, {30'd0, exp_id(m_own[1])});
            chk("rnd_b_vld", {31'd0, vb}, {31'd0, m_own[1] >= 0});
            chk("rnd_b_new", {31'd0, nb}, {31'd0, m_nw[1]});
            chk("rnd_a_onehot", {31'd0, $countones(ga) <= 1}, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_n.md
RR_ARBITER_N -- requirements
Module: rr_arbiter_n

Interface
REQ-001 Parameter N, default 4, meaning number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 8, meaning max consecutive grant cycles under contention; 0 = unlimited; legal range 0..255.
REQ-003 Localparam IDW = max(1, ceil(log2(N))), meaning width of the encoded grant.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req  input  N  request vector; bit i = requester i.
REQ-007 gnt  output  N  registered one-hot grant, or all-zero.
REQ-008 gnt_id  output  IDW  registered binary index of granted requester; 0 when gnt_valid=0.
REQ-009 gnt_valid  output  1  registered; high when any gnt bit is set.
REQ-010 gnt_new  output  1  registered one-cycle pulse in the first cycle of each new grant.

Function
REQ-011 Internal state SHALL be: owner (gnt, gnt_id), rotation pointer ptr (index of last granted requester, IDW bits), hold counter hcnt (8 bits).
REQ-012 States: IDLE (gnt_valid=0) and BUSY (gnt_valid=1); outputs are a pure function of registered state.
REQ-013 Latency: req sampled at edge k SHALL produce gnt at edge k (visible during cycle k+1); one cycle request-to-grant.
REQ-014 Hold: in BUSY with owner o, if req[o]=1 and no forced release applies, gnt SHALL remain unchanged, gnt_new=0, and hcnt SHALL increment, saturating at MAX_HOLD-1 (or 255 if MAX_HOLD=0).
REQ-015 Forced release: if MAX_HOLD!=0, req[o]=1, hcnt==MAX_HOLD-1 and any req[j]=1 for j!=o, arbitration SHALL run with req[o] masked; owner thus holds exactly MAX_HOLD cycles.
REQ-016 Uncontended owner (only req[o]=1) SHALL never be force-released; hcnt saturates.
REQ-017 Arbitration (IDLE, or owner dropped req, or forced release): winner = first set request searching ptr+1, ptr+2, ... wrapping modulo N, ending at ptr.
REQ-018 On a winner w: gnt<=onehot(w), gnt_id<=w, gnt_valid<=1, ptr<=w, hcnt<=0, gnt_new<=1 (also when w equals previous owner after release and re-request).
REQ-019 No winner: gnt<=0, gnt_id<=0, gnt_valid<=0, gnt_new<=0, ptr unchanged, hcnt<=0.
REQ-020 Owner dropping req SHALL hand over at the next edge with no dead cycle when others request.
REQ-021 Wrap-around: ptr=N-1 SHALL search from index 0.
REQ-022 Requests from non-owners during hold SHALL not disturb gnt; no request is lost while held high.
REQ-023 At most one gnt bit SHALL ever be high; gnt_id SHALL always encode gnt.
REQ-024 Fairness: with all N requesting continuously and MAX_HOLD=M>0, every requester SHALL be granted within (N-1)*M cycles of losing.

Reset
REQ-025 rst_n=0 SHALL immediately, without clock, set gnt=0, gnt_id=0, gnt_valid=0, gnt_new=0, hcnt=0, ptr=N-1 (requester 0 has highest first priority).
REQ-026 Reset assertion mid-grant SHALL abort the grant; first edge after rst_n deasserts SHALL arbitrate normally from reset state.

Verification (N=4, MAX_HOLD=4 unless stated)
REQ-027 Reset, then req=0001 -> next edge gnt=0001, gnt_id=0, gnt_valid=1, gnt_new=1 for one cycle only.
REQ-028 req=1111 held -> gnt 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001 ...; gnt_new pulses every 4 cycles.
REQ-029 Only req=0100 held 20 cycles -> gnt=0100 all 20 cycles, single gnt_new, hcnt saturates at 3.
REQ-030 Owner 3 drops req while req=1001->0001 -> next edge gnt=0001 (wrap), no idle cycle.
REQ-031 rst_n pulsed low mid-cycle during gnt=0010 -> all outputs 0 before next edge; after release with req=1111 -> gnt=0001.
REQ-032 MAX_HOLD=0, req=1111 -> gnt=0001 until req[0] drops, then 0010 at next edge.
